wb_arbiter: RTL

WB_ARBITER -- requirements
Module: wb_arbiter

---
 rtl/wb_arbiter.sv | 126 ++++++++++++
 1 files changed

// File: rtl/wb_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : wb_arbiter
// Description : Register-file write-port arbiter between the in-order pipeline
//               and a 2-entry queue of long-latency unit results.
// Revision    : 1.0
// ============================================================================
module wb_arbiter (
    input  logic        clk,
    input  logic        reset,
    input  logic        pipe_valid,
    input  logic [4:0]  pipe_rd,
    input  logic [31:0] pipe_wd,
    input  logic        ll_valid,
    input  logic [4:0]  ll_rd,
    input  logic [31:0] ll_wd,
    output logic        ll_ready,
    output logic        stall_req,
    output logic [31:0] pend_mask,
    output logic        we3,
    output logic [4:0]  wa3,
    output logic [31:0] wd3
);

    localparam int unsigned c_DEPTH     = 2;
    localparam logic [1:0]  c_FULL      = 2'd2;
    localparam logic [2:0]  c_STARVE_MX = 3'd4;

    logic [4:0]  r_q_rd [c_DEPTH];
    logic [31:0] r_q_wd [c_DEPTH];
    logic        r_wptr;
    logic        r_rptr;
    logic [1:0]  r_count;
    logic [2:0]  r_starve;
    logic        r_we3;
    logic [4:0]  r_wa3;
    logic [31:0] r_wd3;

    logic        w_pipe_sel;
    logic        w_empty;
    logic        w_drain;
    logic        w_accept;
    logic        w_enq;
    logic [1:0]  w_entry_vld;
    logic [31:0] w_pend;

    assign w_pipe_sel = pipe_valid && (pipe_rd != 5'd0);
    assign w_empty    = (r_count == 2'd0);
    assign w_drain    = !w_pipe_sel && !w_empty;
    assign ll_ready   = (r_count != c_FULL);
    assign w_accept   = ll_valid && ll_ready;
    // x0 results are accepted to free the LL unit but never occupy a slot
    assign w_enq      = w_accept && (ll_rd != 5'd0);
    assign stall_req  = (r_starve == c_STARVE_MX);

    always_comb begin
        w_entry_vld = '0;
        w_pend      = '0;
        for (int i = 0; i < c_DEPTH; i++) begin
            w_entry_vld[i] = (r_count == c_FULL) ||
                             ((r_count == 2'd1) && (r_rptr == 1'(i)));
            if (w_entry_vld[i]) begin
                w_pend[r_q_rd[i]] = 1'b1;
            end
        end
    end

    assign pend_mask = w_pend;

    always_ff @(posedge clk) begin
        if (w_enq && !reset) begin
            r_q_rd[r_wptr] <= ll_rd;
            r_q_wd[r_wptr] <= ll_wd;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_wptr   <= 1'b0;
            r_rptr   <= 1'b0;
            r_count  <= 2'd0;
            r_starve <= 3'd0;
        end else begin
            if (w_enq) begin
                r_wptr <= ~r_wptr;
            end
            if (w_drain) begin
                r_rptr <= ~r_rptr;
            end
            case ({w_enq, w_drain})
                2'b10:   r_count <= r_count + 2'd1;
                2'b01:   r_count <= r_count - 2'd1;
                default: r_count <= r_count;
            endcase
            if (w_empty || w_drain) begin
                r_starve <= 3'd0;
            end else if (w_pipe_sel && (r_starve != c_STARVE_MX)) begin
                r_starve <= r_starve + 3'd1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_we3 <= 1'b0;
            r_wa3 <= 5'd0;
            r_wd3 <= 32'd0;
        end else if (w_pipe_sel) begin
            r_we3 <= 1'b1;
            r_wa3 <= pipe_rd;
            r_wd3 <= pipe_wd;
        end else if (w_drain) begin
            r_we3 <= 1'b1;
            r_wa3 <= r_q_rd[r_rptr];
            r_wd3 <= r_q_wd[r_rptr];
        end else begin
            r_we3 <= 1'b0;
        end
    end

    assign we3 = r_we3;
    assign wa3 = r_wa3;
    assign wd3 = r_wd3;

endmodule
`default_nettype wire
